mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multiply/divide unit sequencer for the EX stage of the five-stage pipelined MIPS core. It accepts mult/multu/div/divu/mthi/mtlo issue strobes and owns the HI/LO registers. It models the fixed multi-cycle latency of multiply and divide with a countdown state machine, and drives the busy signal that the ID-stage hazard logic uses to stall mfhi/mflo/md instructions.

## Interface
Parameters:
- MULT_CYCLES, default 5: latency of mult/multu in cycles after issue; legal range 1–15.
- DIV_CYCLES, default 10: latency of div/divu in cycles after issue; legal range 1–15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  issue strobe for a valid, non-stalled, non-flushed EX instruction.
- op  in  3  operation code: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; codes 6–7 are no-ops.
- src_a  in  32  rs operand (the dividend, the multiplicand, or the mthi/mtlo source).
- src_b  in  32  rt operand (the divisor or the multiplier).
- hilo_sel  in  1  read select: 0 selects LO, 1 selects HI.
- busy  out  1  high while the unit is occupied.
- done  out  1  one-cycle pulse in the first cycle a new mult/div result is visible.
- rd_data  out  32  combinational read of HI or LO, as chosen by hilo_sel.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

## Operation
- State machine states:
  - IDLE: counter is 0.
  - RUN: counter is nonzero.
- IDLE with start and op ∈ {0..3}:
  - Latch the 64-bit result into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES (for op 0–1) or DIV_CYCLES (for op 2–3).
  - Move to RUN.
- IDLE with start and op ∈ {4,5}:
  - On this edge, HI ← src_a (op 4) or LO ← src_a (op 5).
  - Stay in IDLE; busy and done are unaffected.
- RUN:
  - Decrement the counter every edge.
  - On the edge where the counter goes 1→0: HI ← pending_hi, LO ← pending_lo, return to IDLE, and pulse done for the next cycle. This commit is skipped for a division by zero.
- Arithmetic rules:
  - mult: signed 32×32→64 product; HI = [63:32], LO = [31:0].
  - multu: unsigned 32×32→64 product.
  - div: signed division; LO = quotient truncated toward zero; HI = remainder, which takes the dividend's sign.
  - div special case: 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0x00000000.
  - divu: unsigned division.
  - Divide by zero (src_b = 0, op 2 or 3): full DIV_CYCLES latency with busy asserted; HI and LO keep their pre-issue values; done still pulses.
- start while in RUN, any op: ignored. HI, LO, the counter and the pending registers are all unchanged. The stall logic is required never to produce this case.
- busy = ~reset & (state==RUN | (start & op∈{0..3})). The combinational start term covers the issue cycle.
- rd_data = hilo_sel ? HI : LO. It reflects register contents only and never bypasses pending values or same-cycle mthi/mtlo writes.

## Timing
- Reset (sampled at an edge): state IDLE, counter 0, HI = LO = 0, pending registers 0, done 0. busy reads 0 during any cycle with reset high.
- Reset mid-operation aborts the operation; no commit occurs.
- Issue cycle 0: start and op are sampled at the edge ending cycle 0, and busy is high in cycle 0.
- RUN occupies cycles 1..N, where N is the latency parameter; busy is high throughout.
- Commit happens at the edge ending cycle N.
- Cycle N+1: busy = 0, done = 1, and HI/LO/rd_data show the new values.
- Back-to-back issue: a start in cycle N+1 is accepted, giving zero dead cycles between operations.
- mthi/mtlo issued in cycle t are visible in cycle t+1.

## Test plan
- mult, src_a = 0xFFFFFFFD (−3), src_b = 5:
  - busy high in cycles 0–5; done in cycle 6.
  - HI = 0xFFFFFFFF, LO = 0xFFFFFFF1 in cycle 6.
  - HI/LO unchanged in cycles 1–5.
- multu, 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 in cycle 6. Then issue div −7/2 in cycle 6 → busy in cycles 6–16; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF in cycle 17.
- divu 10/0 after mthi 0x1234 and mtlo 0x5678: busy for 11 cycles; done pulses; HI = 0x1234 and LO = 0x5678 are retained.
- div 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0. In cycle 3 of the same op, issue start with mtlo 0xAAAA and start with mult; both are ignored and the final values are unchanged.
- mult issued, reset asserted in cycle 3:
  - cycle 3: busy = 0.
  - cycle 4: HI = LO = 0, done = 0.
  - cycles 4–10: no later commit or done pulse.
- hilo_sel toggling with mthi 0xDEAD / mtlo 0xBEEF: rd_data = 0xDEAD when hilo_sel = 1 and 0xBEEF when hilo_sel = 0, one cycle after each write and not before.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer for the EX stage: owns HI/LO and models the fixed
// mult/div latency with a countdown so ID-stage hazard logic can stall on busy.
module mdu_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        hilo_sel,
    output logic        busy,
    output logic        done,
    output logic [31:0] rd_data,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_r, state_n;
    logic [3:0]  cnt_r, cnt_n;
    logic [31:0] hi_r, lo_r;
    logic [31:0] pend_hi_r, pend_lo_r;
    logic        dz_r;
    logic        done_r;

    logic        is_md_s;
    logic        dz_s;
    logic        load_s;
    logic        commit_s;
    logic        wr_hi_s;
    logic        wr_lo_s;
    logic [63:0] result_s;

    // 64-bit {HI, LO} result; the divisor is forced nonzero so a divide by
    // zero yields a harmless value that is never committed.
    function automatic logic [63:0] md_result(input logic [2:0]  f_op,
                                              input logic [31:0] f_a,
                                              input logic [31:0] f_b);
        logic signed [63:0] ext_a;
        logic signed [63:0] ext_b;
        logic        [31:0] b_safe;
        logic        [63:0] res;
        ext_a  = {{32{f_a[31]}}, f_a};
        ext_b  = {{32{f_b[31]}}, f_b};
        b_safe = (f_b == 32'd0) ? 32'd1 : f_b;
        res    = 64'd0;
        case (f_op)
            3'd0: res = ext_a * ext_b;
            3'd1: res = {32'd0, f_a} * {32'd0, f_b};
            3'd2: begin
                if ((f_a == 32'h8000_0000) && (f_b == 32'hFFFF_FFFF)) begin
                    res = {32'h0000_0000, 32'h8000_0000};
                end else begin
                    res = {$signed(f_a) % $signed(b_safe), $signed(f_a) / $signed(b_safe)};
                end
            end
            3'd3: res = {f_a % b_safe, f_a / b_safe};
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    assign is_md_s  = start & ~op[2];
    assign dz_s     = op[1] & (src_b == 32'd0);
    assign result_s = md_result(op, src_a, src_b);

    // Next-state, countdown and register-write decode
    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r;
        load_s   = 1'b0;
        commit_s = 1'b0;
        wr_hi_s  = 1'b0;
        wr_lo_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (is_md_s) begin
                    load_s  = 1'b1;
                    cnt_n   = op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                    state_n = RUN;
                end else if (start && (op == 3'd4)) begin
                    wr_hi_s = 1'b1;
                end else if (start && (op == 3'd5)) begin
                    wr_lo_s = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                cnt_n = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    commit_s = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 4'd0;
            end
        endcase
    end

    // FSM state, countdown, pending result and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            dz_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            done_r  <= commit_s;
            if (load_s) begin
                pend_hi_r <= result_s[63:32];
                pend_lo_r <= result_s[31:0];
                dz_r      <= dz_s;
            end
        end
    end

    // Architectural HI/LO: committed results or mthi/mtlo writes
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (commit_s && !dz_r) begin
            hi_r <= pend_hi_r;
            lo_r <= pend_lo_r;
        end else if (wr_hi_s) begin
            hi_r <= src_a;
        end else if (wr_lo_s) begin
            lo_r <= src_a;
        end
    end

    assign busy    = ~reset & ((state_r == RUN) | is_md_s);
    assign done    = done_r;
    assign hi      = hi_r;
    assign lo      = lo_r;
    assign rd_data = hilo_sel ? hi_r : lo_r;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized scoreboard bench for mdu_sequencer: ISA-level HI/LO model, expected
// commits queued at issue and checked by an independent done monitor.
module tb_mdu_sequencer;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_sel;
    logic        busy;
    logic        done;
    logic [31:0] rd_data;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          n_issued = 0;
    int          n_done   = 0;
    logic [31:0] arch_hi  = 32'd0;
    logic [31:0] arch_lo  = 32'd0;

    mdu_sequencer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .hilo_sel(hilo_sel),
        .busy    (busy),
        .done    (done),
        .rd_data (rd_data),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: ISA arithmetic on 64-bit integers, {HI, LO}
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, ma, mb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        res = 64'd0;
        if (o == 3'd0) begin
            res = sa * sb;
        end else if (o == 3'd1) begin
            res = ua * ub;
        end else if (b != 32'd0 && o == 3'd2) begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q  = ma / mb;
            if ((sa < 0) != (sb < 0)) q = -q;
            r  = sa - q * sb;
            res = {r[31:0], q[31:0]};
        end else if (b != 32'd0 && o == 3'd3) begin
            res = {32'(ua % ub), 32'(ua / ub)};
        end
        return res;
    endfunction

    // Issue mult/div in the current cycle; optionally inject ignored starts in cycles 3 and 4
    task automatic md_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        int          n;
        logic [63:0] r;
        logic [31:0] pre_hi, pre_lo;
        exp_t        e;
        n      = (o < 3'd2) ? MULT_CYCLES : DIV_CYCLES;
        pre_hi = arch_hi;
        pre_lo = arch_lo;
        r      = ref_result(o, a, b);
        if (o >= 3'd2 && b == 32'd0) begin
            e.hi = arch_hi;
            e.lo = arch_lo;
        end else begin
            e.hi = r[63:32];
            e.lo = r[31:0];
        end
        arch_hi = e.hi;
        arch_lo = e.lo;
        exp_q.push_back(e);
        n_issued++;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        check("busy_issue", {31'd0, busy}, 32'd1);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (inject && c == 3) begin start = 1'b1; op = 3'd5; src_a = 32'h0000_AAAA; end
            if (inject && c == 4) begin start = 1'b1; op = 3'd0; src_a = $urandom; src_b = $urandom; end
            @(negedge clk);
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_run", {31'd0, done}, 32'd0);
            check("hi_hold", hi, pre_hi);
            check("lo_hold", lo, pre_lo);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mthi/mtlo/no-op issued while idle: invisible this cycle, visible next
    task automatic mt_op(input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; src_a = a; src_b = $urandom;
        @(negedge clk);
        check("busy_mt", {31'd0, busy}, 32'd0);
        check("rd_before", rd_data, hilo_sel ? arch_hi : arch_lo);
        @(posedge clk); #1;
        start = 1'b0;
        if (o == 3'd4) arch_hi = a;
        if (o == 3'd5) arch_lo = a;
        @(negedge clk);
        check("hi_mt", hi, arch_hi);
        check("lo_mt", lo, arch_lo);
        check("rd_after", rd_data, hilo_sel ? arch_hi : arch_lo);
        @(posedge clk); #1;
    endtask

    // Monitor: every done pulse pops one expected commit
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_unexpected: got done=1 expected no pulse at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("commit_hi", hi, e.hi);
                check("commit_lo", lo, e.lo);
                check("commit_rd", rd_data, hilo_sel ? e.hi : e.lo);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b1; op = 3'd0; src_a = 32'd7; src_b = 32'd9; hilo_sel = 1'b0;
        @(negedge clk);
        check("busy_in_reset", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        @(posedge clk); #1;

        md_op(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        md_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        md_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        @(posedge clk); #1;
        mt_op(3'd4, 32'h0000_1234);
        mt_op(3'd5, 32'h0000_5678);
        md_op(3'd3, 32'd10, 32'd0, 1'b0);
        @(posedge clk); #1;
        md_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;

        hilo_sel = 1'b1;
        mt_op(3'd4, 32'h0000_DEAD);
        hilo_sel = 1'b0;
        mt_op(3'd5, 32'h0000_BEEF);
        hilo_sel = 1'b1;
        @(negedge clk);
        check("rd_sel_hi", rd_data, 32'h0000_DEAD);
        @(posedge clk); #1;
        hilo_sel = 1'b0;
        @(negedge clk);
        check("rd_sel_lo", rd_data, 32'h0000_BEEF);
        @(posedge clk); #1;

        // Reset in cycle 3 of a mult aborts it
        start = 1'b1; op = 3'd0; src_a = 32'd1000; src_b = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("busy_reset_mid", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        arch_hi = 32'd0;
        arch_lo = 32'd0;
        @(negedge clk);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        for (int c = 5; c <= 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
            check("abort_hi_hold", hi, 32'd0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            hilo_sel = 1'($urandom_range(0, 1));
            if (o < 3'd4) begin
                md_op(o, a, b, 1'b0);
            end else begin
                mt_op(o, a);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("done_count", n_done, n_issued);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
